// File: rtl/partial_boundary_driver_pkg.sv
// partial_boundary_driver_pkg: shared sizing helpers for the partial-circuit boundary driver.
package partial_boundary_driver_pkg;

    localparam int LATENCY_MAX = 15;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Wide enough to hold inflight + fifo_count without overflow.
    function automatic int credit_w(input int latency, input int depth);
        int a;
        int b;
        a = clog2(latency + 2);
        b = clog2(depth) + 1;
        return ((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/partial_resp_fifo.sv
// partial_resp_fifo: synchronous response FIFO with MSB-wrap pointers and no bypass.
module partial_resp_fifo
    import partial_boundary_driver_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       ASYNCRESETN,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [clog2(DEPTH):0]      count,
    output logic                       empty
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    assign count = wr_q - rd_q;
    assign empty = (count == '0);
    assign dout  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (AW+1)'(push);
            rd_q <= rd_q + (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/partial_boundary_driver.sv
// partial_boundary_driver: drives cut inputs of a partial circuit and returns its outputs
// LATENCY edges later through a credit-protected response FIFO.
module partial_boundary_driver
    import partial_boundary_driver_pkg::*;
#(
    parameter int                NUM_IN  = 1,
    parameter int                NUM_OUT = 1,
    parameter int                LATENCY = 2,
    parameter int                DEPTH   = 4,
    parameter logic [NUM_IN-1:0] I_INIT  = '0
) (
    input  logic               CLK,
    input  logic               ASYNCRESETN,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [NUM_IN-1:0]  load_data,
    output logic [NUM_IN-1:0]  I,
    input  logic [NUM_OUT-1:0] O,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [NUM_OUT-1:0] resp_data,
    output logic               busy
);
    localparam int AW = clog2(DEPTH);
    localparam int IW = clog2(LATENCY + 2);
    localparam int CW = credit_w(LATENCY, DEPTH);

    logic [NUM_IN-1:0] i_q;
    logic [LATENCY:0]  tag_q;
    logic [LATENCY:0]  tag_d;
    logic [IW-1:0]     inflight;
    logic [AW:0]       count;
    logic              empty;
    logic              fire;
    logic              pop;

    // Credit uses registered state only, so a same-cycle pop frees a slot one cycle later.
    assign load_ready = (CW'(inflight) + CW'(count)) < CW'(DEPTH);
    assign fire       = load_valid & load_ready;
    assign pop        = resp_valid & resp_ready;
    assign resp_valid = !empty;
    assign busy       = |tag_q;
    assign I          = i_q;

    always_comb begin
        tag_d    = '0;
        tag_d[0] = fire;
        for (int j = 1; j <= LATENCY; j++) tag_d[j] = tag_q[j-1];
        inflight = '0;
        for (int j = 0; j <= LATENCY; j++) inflight = inflight + IW'(tag_q[j]);
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            i_q   <= I_INIT;
            tag_q <= '0;
        end else begin
            if (fire) i_q <= load_data;
            tag_q <= tag_d;
        end
    end

    // The tag leaving the pipe marks the cycle whose O belongs to that vector.
    partial_resp_fifo #(
        .WIDTH (NUM_OUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .push        (tag_q[LATENCY]),
        .din         (O),
        .pop         (pop),
        .dout        (resp_data),
        .count       (count),
        .empty       (empty)
    );

endmodule

// File: tb/tb_partial_boundary_driver.sv
// tb_partial_boundary_driver: directed bench with a two-register inverter cut (LATENCY=2)
// and a combinational 4-bit inverter cut (LATENCY=0).
module tb_partial_boundary_driver;
    logic CLK = 0;
    logic ASYNCRESETN;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    logic       a_lv, a_lr, a_ld, a_i, a_o, a_rv, a_rr, a_rd, a_busy;
    logic       inv_r1, inv_r2;
    logic       b_lv, b_lr, b_rv, b_rr, b_busy;
    logic [3:0] b_ld, b_i, b_rd;

    always_ff @(posedge CLK) begin
        inv_r1 <= ~a_i;
        inv_r2 <= inv_r1;
    end
    assign a_o = inv_r2;

    partial_boundary_driver #(.NUM_IN(1), .NUM_OUT(1), .LATENCY(2), .DEPTH(4), .I_INIT(1'b0)) dut_a (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .load_valid(a_lv), .load_ready(a_lr),
        .load_data(a_ld), .I(a_i), .O(a_o), .resp_valid(a_rv), .resp_ready(a_rr),
        .resp_data(a_rd), .busy(a_busy));

    partial_boundary_driver #(.NUM_IN(4), .NUM_OUT(4), .LATENCY(0), .DEPTH(4), .I_INIT(4'h0)) dut_b (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .load_valid(b_lv), .load_ready(b_lr),
        .load_data(b_ld), .I(b_i), .O(~b_i), .resp_valid(b_rv), .resp_ready(b_rr),
        .resp_data(b_rd), .busy(b_busy));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        a_lv = 0; a_rr = 1; b_lv = 0; b_rr = 1;
        repeat (n) step();
    endtask

    task automatic test_reset();
        n_chk++; if (a_i !== 1'b0) begin n_fail++; $display("FAIL reset_I got %b want 0", a_i); end
        n_chk++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", a_rv); end
        n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", a_busy); end
        n_chk++; if (a_lr !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got %b want 1", a_lr); end
        n_chk++; if (b_lr !== 1'b1 || b_rv !== 1'b0 || b_i !== 4'h0) begin
            n_fail++; $display("FAIL reset_b got lr=%b rv=%b I=%h want 1 0 0", b_lr, b_rv, b_i); end
    endtask

    task automatic test_single();
        logic [2:0] bz = 3'b111;
        a_rr = 0; a_lv = 1; a_ld = 1;
        step();
        a_lv = 0;
        n_chk++; if (a_i !== 1'b1) begin n_fail++; $display("FAIL single_I got %b want 1", a_i); end
        for (int e = 0; e < 3; e++) begin
            n_chk++; if (a_busy !== bz[e]) begin n_fail++; $display("FAIL single_busy edge %0d got %b want 1", e, a_busy); end
            n_chk++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL single_early_valid edge %0d got %b want 0", e, a_rv); end
            step();
        end
        n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", a_busy); end
        n_chk++; if (a_rv !== 1'b1 || a_rd !== 1'b0) begin
            n_fail++; $display("FAIL single_resp got v=%b d=%b want v=1 d=0", a_rv, a_rd); end
        a_rr = 1;
        step();
        n_chk++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL single_pop got %b want 0", a_rv); end
    endtask

    task automatic test_stream();
        logic [3:0] vec = 4'b1101;
        a_rr = 1;
        for (int c = 0; c < 7; c++) begin
            a_lv = (c < 4);
            a_ld = (c < 4) ? vec[c] : 1'b0;
            if (c < 4) begin
                n_chk++; if (a_lr !== 1'b1) begin n_fail++; $display("FAIL stream_ready cycle %0d got %b want 1", c, a_lr); end
            end
            step();
            if (c >= 3) begin
                n_chk++; if (a_rv !== 1'b1 || a_rd !== ~vec[c-3]) begin
                    n_fail++; $display("FAIL stream_resp %0d got v=%b d=%b want v=1 d=%b", c-3, a_rv, a_rd, ~vec[c-3]); end
            end
        end
        a_lv = 0;
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int nf = 0;
        a_rr = 0; a_lv = 1;
        for (int c = 0; c < 8; c++) begin
            a_ld = (nf < 4) ? pat[nf] : 1'b0;
            if (a_lr) nf++;
            step();
            if (c == 3) begin
                n_chk++; if (a_lr !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop got %b want 0", a_lr); end
            end
        end
        a_lv = 0;
        n_chk++; if (nf != 4) begin n_fail++; $display("FAIL bp_fires got %0d want 4", nf); end
        n_chk++; if (dut_a.u_fifo.count !== 3'd4) begin n_fail++; $display("FAIL bp_count got %0d want 4", dut_a.u_fifo.count); end
        n_chk++; if (a_lr !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b want 0", a_lr); end
        a_rr = 1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (a_rv !== 1'b1 || a_rd !== ~pat[i]) begin
                n_fail++; $display("FAIL bp_drain %0d got v=%b d=%b want v=1 d=%b", i, a_rv, a_rd, ~pat[i]); end
            step();
            if (i == 0) begin
                n_chk++; if (a_lr !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return got %b want 1", a_lr); end
            end
        end
        n_chk++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", a_rv); end
    endtask

    task automatic test_push_pop_full();
        logic [3:0] d = 4'b1011;
        a_rr = 0;
        for (int c = 0; c < 4; c++) begin
            a_lv = 1; a_ld = d[c];
            step();
        end
        a_lv = 0;
        step();
        step();
        n_chk++; if (dut_a.u_fifo.count !== 3'd3) begin n_fail++; $display("FAIL pp_count_before got %0d want 3", dut_a.u_fifo.count); end
        a_rr = 1;
        n_chk++; if (a_rd !== ~d[0]) begin n_fail++; $display("FAIL pp_head got %b want %b", a_rd, ~d[0]); end
        step();
        n_chk++; if (dut_a.u_fifo.count !== 3'd3) begin n_fail++; $display("FAIL pp_count_after got %0d want 3", dut_a.u_fifo.count); end
        for (int i = 1; i < 4; i++) begin
            n_chk++; if (a_rv !== 1'b1 || a_rd !== ~d[i]) begin
                n_fail++; $display("FAIL pp_order %0d got v=%b d=%b want v=1 d=%b", i, a_rv, a_rd, ~d[i]); end
            step();
        end
        n_chk++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL pp_empty got %b want 0", a_rv); end
    endtask

    task automatic test_reset_midstream();
        a_rr = 1; a_lv = 1; a_ld = 1;
        step();
        step();
        a_lv = 0;
        #2 ASYNCRESETN = 0;
        #1;
        n_chk++; if (a_i !== 1'b0) begin n_fail++; $display("FAIL mid_I got %b want 0", a_i); end
        n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", a_busy); end
        n_chk++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL mid_resp_valid got %b want 0", a_rv); end
        step();
        #2 ASYNCRESETN = 1;
        for (int c = 0; c < 6; c++) begin
            step();
            n_chk++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL mid_stale cycle %0d got %b want 0", c, a_rv); end
        end
    endtask

    task automatic test_latency0();
        b_rr = 0; b_lv = 1; b_ld = 4'hA;
        step();
        b_lv = 0;
        n_chk++; if (b_i !== 4'hA) begin n_fail++; $display("FAIL l0_I got %h want a", b_i); end
        n_chk++; if (b_rv !== 1'b0 || b_busy !== 1'b1) begin
            n_fail++; $display("FAIL l0_edge0 got v=%b busy=%b want 0 1", b_rv, b_busy); end
        step();
        n_chk++; if (b_rv !== 1'b1 || b_rd !== 4'h5 || b_busy !== 1'b0) begin
            n_fail++; $display("FAIL l0_resp got v=%b d=%h busy=%b want 1 5 0", b_rv, b_rd, b_busy); end
        b_rr = 1;
        step();
        n_chk++; if (b_rv !== 1'b0) begin n_fail++; $display("FAIL l0_pop got %b want 0", b_rv); end
    endtask

    initial begin
        ASYNCRESETN = 0;
        a_lv = 0; a_ld = 0; a_rr = 0; b_lv = 0; b_ld = 0; b_rr = 0;
        #12 ASYNCRESETN = 1;
        step();
        test_reset();
        test_single();
        idle(4);
        test_stream();
        idle(4);
        test_backpressure();
        idle(4);
        test_push_pop_full();
        idle(4);
        test_reset_midstream();
        idle(2);
        test_latency0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/partial_boundary_driver.md
Name: partial_boundary_driver

Overview:
- Stimulus/response harness for partial circuits produced by the cut-extraction flow, which expose flattened boundary inputs I0..In and outputs O0..Om.
- Accepts input vectors over a valid/ready port and drives them onto the cut inputs.
- Samples the cut outputs a fixed LATENCY later and returns them in order through a buffered valid/ready response port.
- Used to exercise extracted register-to-register paths in silicon-less emulation and in simulation benches.

Parameters:
- NUM_IN, 1, width of the cut-input vector driven to the partial circuit.
- NUM_OUT, 1, width of the cut-output vector sampled from the partial circuit.
- LATENCY, 2, clock edges from applying I to O being valid; legal range 0..15.
- DEPTH, 4, response FIFO entries; power of two, at least 2.
- I_INIT, 0, value of I out of reset, NUM_IN bits.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- ASYNCRESETN  in  1  reset, asynchronous, active-low.
- load_valid  in  1  input vector offered.
- load_ready  out  1  vector can be accepted this cycle.
- load_data  in  NUM_IN  vector to apply.
- I  out  NUM_IN  registered drive to the partial circuit's cut inputs.
- O  in  NUM_OUT  cut outputs from the partial circuit.
- resp_valid  out  1  FIFO head valid.
- resp_ready  in  1  consumer pops the head.
- resp_data  out  NUM_OUT  sampled output for the oldest accepted vector.
- busy  out  1  one or more vectors are in flight, not yet captured.

Behaviour:
- Reset (async assert, sync to CLK on release):
  - I=I_INIT; inflight tag pipe cleared; FIFO empty.
  - resp_valid=0, busy=0, load_ready=1.
- Load fire: load_valid & load_ready at edge k.
  - I<=load_data at edge k. I holds that value until the next fire.
  - tag[0] set at edge k. The tag pipe shifts every edge, so tag[j] is high after edge k+j.
- Capture: when tag[LATENCY] is high, O is pushed into the FIFO at the next edge (k+LATENCY+1).
  - resp_valid is visible after edge k+LATENCY+1, giving load-to-resp latency LATENCY+1 cycles.
  - LATENCY=0 means a combinational cut: O is sampled at edge k+1.
- Back-to-back fires on consecutive edges are legal. Responses emerge on consecutive cycles, in order.
- Credit:
  - inflight = number of set tags (0..LATENCY+1).
  - load_ready = (inflight + fifo_count) < DEPTH, computed from registered state only.
  - A pop in the same cycle does not grant credit until the next cycle.
  - The FIFO can therefore never overflow, and O capture is never dropped, even when resp_ready stays low.
- FIFO:
  - Pop when resp_valid & resp_ready. Simultaneous push and pop at any occupancy keeps the count unchanged.
  - No bypass: a push into an empty FIFO gives resp_valid on the following cycle.
  - resp_data is the head entry; it is don't-care when resp_valid=0.
- busy = OR of the tag pipe.
- Reset mid-operation: in-flight tags and buffered responses are discarded, and I returns to I_INIT immediately on assertion.
- Widths: the FIFO pointers have log2(DEPTH)+1 bits, with wrap via the MSB. The inflight counter has clog2(LATENCY+2) bits.

Decomposition:
- Shared package: clog2 helper function; LATENCY_MAX=15 constant; credit-count width calculation.
- One sub-module: partial_resp_fifo. Synchronous FIFO with parameters WIDTH and DEPTH, ports push/din/pop/dout/count/empty, and the same CLK/ASYNCRESETN.
- The top level holds the I register, the tag pipe and the credit logic.

Test Plan:
- DUT wired to the two-register inverter partial circuit (O = ~I delayed 2 edges), LATENCY=2.
- Single vector: load 1 at edge 0 -> I=1 after edge 0; resp_valid=1 and resp_data=0 after edge 3; busy high after edges 0..2 only.
- Stream: load 1,0,1,1 on edges 0..3 with resp_ready=1 -> resp_data 0,1,0,0 on cycles after edges 3..6; load_ready never drops.
- Backpressure: resp_ready=0, DEPTH=4, load_valid=1 continuously -> exactly 4 fires (edges 0..3); load_ready=0 after edge 3; 4 entries held; raise resp_ready -> one pop per cycle, and load_ready returns one cycle after the first pop.
- Simultaneous push/pop at count=DEPTH-1 -> count is unchanged and data order is preserved.
- Reset mid-stream: assert ASYNCRESETN=0 between edges 1 and 2 with two vectors in flight -> immediately I=I_INIT, resp_valid=0, busy=0; after release, no stale response ever appears.
- LATENCY=0 with a combinational inverter cut: load 0xA (NUM_IN=NUM_OUT=4) at edge 0 -> resp_data=0x5 after edge 1.
